// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

  localparam int BLOCK_WIDTH_DEF = 1;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  typedef enum logic [1:0] {
    CL_IC = 2'd0,
    CL_LD = 2'd1,
    CL_ST = 2'd2
  } client_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IC = 2'd1,
    S_BUSY_LD = 2'd2,
    S_BUSY_ST = 2'd3
  } state_e;

  // Sign- or zero-extend the low 8*width bits of an assembled load word.
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [2:0]  width,
                                              input logic        sgn);
    case (width)
      W_BYTE:  return sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      W_HALF:  return sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_grant3.sv
// Three-way one-hot grant (bit0=IC, bit1=LD, bit2=ST).
// MEM_ARB_RR_EN: rotating priority starting at ptr_i; otherwise fixed ST > LD > IC.
module rr_grant3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
`ifdef MEM_ARB_RR_EN
  input  client_e    ptr_i,
`endif
  output logic [2:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
  // Search the requests in rotating order beginning at the pointer.
  always_comb begin
    gnt_o = 3'b000;
    case (ptr_i)
      CL_LD: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      CL_ST: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end
`else
  // Stores drain first so committed state reaches memory ahead of new reads.
  always_comb begin
    gnt_o = 3'b000;
    if      (req_i[2]) gnt_o = 3'b100;
    else if (req_i[1]) gnt_o = 3'b010;
    else if (req_i[0]) gnt_o = 3'b001;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter in front of MemController: serialises ICache fetches, loads and
// stores so only one MemController enable is ever high, assembles load bytes
// and squashes loads across a pipeline flush.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
//
// state     | meaning
// S_IDLE    | no transaction; grant one eligible requester
// S_BUSY_IC | block read in progress at MemController
// S_BUSY_LD | load in progress, bytes collected into asm_q
// S_BUSY_ST | store in progress
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
  input  logic                      Sys_clk,
  input  logic                      Sys_rst_n,
  input  logic                      Sys_rdy,
  input  logic                      RoB_flush,
  input  logic                      ICARB_en,
  input  logic [31:0]               ICARB_addr,
  output logic                      ARBIC_en,
  output logic [32*BLOCK_SIZE-1:0]  ARBIC_block,
  input  logic                      LDARB_en,
  input  logic [31:0]               LDARB_addr,
  input  logic [2:0]                LDARB_width,
  input  logic                      LDARB_signed,
  output logic                      ARBLD_en,
  output logic [31:0]               ARBLD_data,
  input  logic                      STARB_en,
  input  logic [31:0]               STARB_addr,
  input  logic [2:0]                STARB_width,
  input  logic [31:0]               STARB_data,
  output logic                      ARBST_en,
  output logic                      ARBMC_ic_en,
  output logic [31:0]               ARBMC_ic_addr,
  output logic                      ARBMC_lsb_en,
  output logic                      ARBMC_lsb_wr,
  output logic [2:0]                ARBMC_lsb_width,
  output logic [31:0]               ARBMC_lsb_data,
  output logic [31:0]               ARBMC_lsb_addr,
  input  logic                      MCARB_ic_en,
  input  logic [32*BLOCK_SIZE-1:0]  MCARB_ic_block,
  input  logic                      MCARB_lsb_en,
  input  logic [7:0]                MCARB_lsb_data,
  input  logic [1:0]                MCARB_lsb_data_number
);

  state_e                    state_q, state_d;
  logic                      squash_q, squash_d;
  logic [31:0]               addr_q, addr_d;
  logic [2:0]                width_q, width_d;
  logic [31:0]               data_q, data_d;
  logic                      sgn_q, sgn_d;
  logic [31:0]               asm_q, asm_d;
  logic                      ic_done_q, ic_done_d;
  logic                      ld_done_q, ld_done_d;
  logic                      st_done_q, st_done_d;
  logic [32*BLOCK_SIZE-1:0]  block_q, block_d;
  logic [31:0]               ld_data_q, ld_data_d;

  logic [2:0]  req;
  logic [2:0]  gnt;
  logic        mc_lsb_done;
  logic [2:0]  lane;
  logic [31:0] merged;

  // A client whose done pulse is showing has not yet dropped its request.
  assign req = {STARB_en & ~st_done_q,
                LDARB_en & ~RoB_flush & ~ld_done_q,
                ICARB_en & ~ic_done_q};

`ifdef MEM_ARB_RR_EN
  client_e ptr_q, ptr_d;

  // Pointer moves to the client after the one just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE) begin
      if      (gnt[0]) ptr_d = CL_LD;
      else if (gnt[1]) ptr_d = CL_ST;
      else if (gnt[2]) ptr_d = CL_IC;
    end
  end
`endif

  rr_grant3 u_grant (
    .req_i (req),
`ifdef MEM_ARB_RR_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt)
  );

  // Final-byte detection; loads return bytes counting data_number down to 0.
  always_comb begin
    mc_lsb_done = 1'b0;
    if (state_q == S_BUSY_ST)      mc_lsb_done = MCARB_lsb_en;
    else if (state_q == S_BUSY_LD) mc_lsb_done = MCARB_lsb_en && (MCARB_lsb_data_number == 2'd0);
  end

  assign lane = width_q - 3'd1 - {1'b0, MCARB_lsb_data_number};

  // Merge the returning byte into its lane of the assembly word.
  always_comb begin
    merged = asm_q;
    for (int b = 0; b < 4; b++) begin
      if (lane == 3'(b)) merged[8*b +: 8] = MCARB_lsb_data;
    end
  end

  // Next-state logic; done pulses default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    squash_d  = squash_q;
    addr_d    = addr_q;
    width_d   = width_q;
    data_d    = data_q;
    sgn_d     = sgn_q;
    asm_d     = asm_q;
    block_d   = block_q;
    ld_data_d = ld_data_q;
    ic_done_d = 1'b0;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt[0]) begin
          state_d = S_BUSY_IC;
          addr_d  = ICARB_addr;
        end else if (gnt[1]) begin
          state_d  = S_BUSY_LD;
          addr_d   = LDARB_addr;
          width_d  = LDARB_width;
          sgn_d    = LDARB_signed;
          squash_d = 1'b0;
          asm_d    = 32'h0;
        end else if (gnt[2]) begin
          state_d = S_BUSY_ST;
          addr_d  = STARB_addr;
          width_d = STARB_width;
          data_d  = STARB_data;
        end
      end
      S_BUSY_IC: begin
        if (MCARB_ic_en) begin
          block_d   = MCARB_ic_block;
          ic_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_BUSY_LD: begin
        if (RoB_flush) squash_d = 1'b1;
        if (MCARB_lsb_en) begin
          asm_d = merged;
          if (mc_lsb_done) begin
            ld_data_d = extend_load(merged, width_q, sgn_q);
            ld_done_d = !(squash_q || RoB_flush);
            squash_d  = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      S_BUSY_ST: begin
        if (mc_lsb_done) begin
          st_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers: synchronous reset, frozen while Sys_rdy is low.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      state_q   <= S_IDLE;
      squash_q  <= 1'b0;
      addr_q    <= 32'h0;
      width_q   <= 3'h0;
      data_q    <= 32'h0;
      sgn_q     <= 1'b0;
      asm_q     <= 32'h0;
      ic_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      block_q   <= '0;
      ld_data_q <= 32'h0;
`ifdef MEM_ARB_RR_EN
      ptr_q     <= CL_IC;
`endif
    end else if (Sys_rdy) begin
      state_q   <= state_d;
      squash_q  <= squash_d;
      addr_q    <= addr_d;
      width_q   <= width_d;
      data_q    <= data_d;
      sgn_q     <= sgn_d;
      asm_q     <= asm_d;
      ic_done_q <= ic_done_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      block_q   <= block_d;
      ld_data_q <= ld_data_d;
`ifdef MEM_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // Enables drop combinationally in the done cycle so MemController does not re-serve.
  assign ARBMC_ic_en     = (state_q == S_BUSY_IC) && !MCARB_ic_en;
  assign ARBMC_lsb_en    = ((state_q == S_BUSY_LD) || (state_q == S_BUSY_ST)) && !mc_lsb_done;
  assign ARBMC_lsb_wr    = (state_q == S_BUSY_ST);
  assign ARBMC_ic_addr   = addr_q;
  assign ARBMC_lsb_addr  = addr_q;
  assign ARBMC_lsb_width = width_q;
  assign ARBMC_lsb_data  = data_q;
  assign ARBIC_en        = ic_done_q;
  assign ARBIC_block     = block_q;
  assign ARBLD_en        = ld_done_q;
  assign ARBLD_data      = ld_data_q;
  assign ARBST_en        = st_done_q;

  a_width_legal: assert property (@(posedge Sys_clk) disable iff (!Sys_rst_n)
    ((state_q == S_BUSY_LD) || (state_q == S_BUSY_ST)) |->
    ((width_q == W_BYTE) || (width_q == W_HALF) || (width_q == W_WORD)));

endmodule
